// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the channel-sum adder sequencer: FSM encoding,
// read-latency bounds and the channel-count to mask conversion.
package adder_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } addseq_state_t;

   localparam int MEM_RD_LATENCY_MIN = 1;
   localparam int MEM_RD_LATENCY_MAX = 4;

   // Thermometer mask: bit i selects channel i+1; illegal counts select nothing.
   function automatic logic [2:0] channel_mask(input logic [2:0] channels);
      logic [2:0] mask_s;
      case (channels)
         3'd1:    mask_s = 3'b001;
         3'd2:    mask_s = 3'b011;
         3'd3:    mask_s = 3'b111;
         default: mask_s = 3'b000;
      endcase
      return mask_s;
   endfunction

endpackage

// File: rtl/adder_sequencer_delay_line.sv
// Shift register carrying {valid, addr} from the read port to the output-memory
// write port, with an intermediate valid tap for the adder enable.
module adder_sequencer_delay_line #(
   parameter int ADDR_W = 22,
   parameter int DEPTH  = 2,
   parameter int TAP    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              tap_valid,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr
);

   logic [DEPTH-1:0]  valid_r;
   logic [ADDR_W-1:0] addr_r [DEPTH];

   // Advance every stage by one each cycle; reset empties the pipe at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_r[i] <= '0;
         end
      end else begin
         valid_r   <= {valid_r[DEPTH-2:0], in_valid};
         addr_r[0] <= in_addr;
         for (int i = 1; i < DEPTH; i++) begin
            addr_r[i] <= addr_r[i-1];
         end
      end
   end

   assign tap_valid = valid_r[TAP-1];
   assign out_valid = valid_r[DEPTH-1];
   assign out_addr  = addr_r[DEPTH-1];

endmodule

// File: rtl/adder_sequencer.sv
// Walks output-feature addresses over the channel memories, aligns adder enable
// and output write with read latency, and reports completion to the top controller.
module adder_sequencer
   import adder_sequencer_pkg::*;
#(
   parameter int BITWIDTH_MAX_IF_SIZE = 22,
   parameter int BITWIDTH_IF_CHANNELS = 3,
   parameter int MEM_RD_LATENCY       = 1,
   parameter int MAX_CHANNELS         = 3
) (
   input  logic                            ADDSEQ_Clk,
   input  logic                            ADDSEQ_Reset,
   input  logic                            ADDSEQ_Start_Routine,
   input  logic                            ADDSEQ_Routine_Finished_Already_Ok,
   input  logic [BITWIDTH_IF_CHANNELS-1:0] ADDSEQ_If_Channels,
   input  logic [BITWIDTH_MAX_IF_SIZE-1:0] ADDSEQ_Of_Size,
   output logic                            ADDSEQ_Mems_Re,
   output logic [BITWIDTH_MAX_IF_SIZE-1:0] ADDSEQ_Mems_Rd_Addr,
   output logic                            ADDSEQ_Adder_En,
   output logic [2:0]                      ADDSEQ_Channel_Mask,
   output logic                            ADDSEQ_Out_Mem_We,
   output logic [BITWIDTH_MAX_IF_SIZE-1:0] ADDSEQ_Out_Mem_Wr_Addr,
   output logic                            ADDSEQ_Busy,
   output logic                            ADDSEQ_Config_Error,
   output logic                            ADDSEQ_Routine_Finished_Already
);

   // Out-of-range latencies are pinned to the supported window.
   localparam int LAT = (MEM_RD_LATENCY < MEM_RD_LATENCY_MIN) ? MEM_RD_LATENCY_MIN :
                        (MEM_RD_LATENCY > MEM_RD_LATENCY_MAX) ? MEM_RD_LATENCY_MAX :
                        MEM_RD_LATENCY;
   localparam logic [BITWIDTH_MAX_IF_SIZE-1:0] ADDR_ONE = BITWIDTH_MAX_IF_SIZE'(1);
   localparam logic [BITWIDTH_IF_CHANNELS-1:0] MAX_CH   = BITWIDTH_IF_CHANNELS'(MAX_CHANNELS);

   addseq_state_t                   state_r;
   logic                            re_r;
   logic [BITWIDTH_MAX_IF_SIZE-1:0] rd_addr_r;
   logic [BITWIDTH_MAX_IF_SIZE-1:0] of_size_q_r;
   logic [2:0]                      mask_r;
   logic                            busy_r;
   logic                            cfg_err_r;
   logic                            finished_r;
   logic                            chan_illegal_s;
   logic                            adder_en_s;
   logic                            we_s;
   logic [BITWIDTH_MAX_IF_SIZE-1:0] wr_addr_s;

   assign chan_illegal_s = (ADDSEQ_If_Channels == '0) || (ADDSEQ_If_Channels > MAX_CH);

   // Sequencer FSM with address counter and all control outputs registered.
   always_ff @(posedge ADDSEQ_Clk or posedge ADDSEQ_Reset) begin
      if (ADDSEQ_Reset) begin
         state_r     <= ST_IDLE;
         re_r        <= 1'b0;
         rd_addr_r   <= '0;
         of_size_q_r <= '0;
         mask_r      <= 3'b000;
         busy_r      <= 1'b0;
         cfg_err_r   <= 1'b0;
         finished_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ADDSEQ_Start_Routine) begin
                  of_size_q_r <= ADDSEQ_Of_Size;
                  cfg_err_r   <= chan_illegal_s;
                  if (chan_illegal_s) begin
                     state_r    <= ST_DONE;
                     finished_r <= 1'b1;
                  end else begin
                     state_r   <= ST_RUN;
                     re_r      <= 1'b1;
                     rd_addr_r <= '0;
                     busy_r    <= 1'b1;
                     mask_r    <= channel_mask(3'(ADDSEQ_If_Channels));
                  end
               end
            end
            ST_RUN: begin
               // Compare-equal ends the walk, so Of_Size = 0 yields a single read.
               if (rd_addr_r == of_size_q_r) begin
                  re_r    <= 1'b0;
                  state_r <= ST_DRAIN;
               end else begin
                  rd_addr_r <= rd_addr_r + ADDR_ONE;
               end
            end
            ST_DRAIN: begin
               // Valid entries are contiguous: a write with nothing at the adder tap is the last one.
               if (we_s && !adder_en_s) begin
                  state_r    <= ST_DONE;
                  busy_r     <= 1'b0;
                  finished_r <= 1'b1;
               end
            end
            ST_DONE: begin
               if (ADDSEQ_Routine_Finished_Already_Ok) begin
                  state_r    <= ST_IDLE;
                  finished_r <= 1'b0;
                  mask_r     <= 3'b000;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   adder_sequencer_delay_line #(
      .ADDR_W (BITWIDTH_MAX_IF_SIZE),
      .DEPTH  (LAT + 1),
      .TAP    (LAT)
   ) u_delay_line (
      .clk       (ADDSEQ_Clk),
      .rst       (ADDSEQ_Reset),
      .in_valid  (re_r),
      .in_addr   (rd_addr_r),
      .tap_valid (adder_en_s),
      .out_valid (we_s),
      .out_addr  (wr_addr_s)
   );

   assign ADDSEQ_Mems_Re                  = re_r;
   assign ADDSEQ_Mems_Rd_Addr             = rd_addr_r;
   assign ADDSEQ_Adder_En                 = adder_en_s;
   assign ADDSEQ_Channel_Mask             = mask_r;
   assign ADDSEQ_Out_Mem_We               = we_s;
   assign ADDSEQ_Out_Mem_Wr_Addr          = wr_addr_s;
   assign ADDSEQ_Busy                     = busy_r;
   assign ADDSEQ_Config_Error             = cfg_err_r;
   assign ADDSEQ_Routine_Finished_Already = finished_r;

endmodule

// File: tb/tb_adder_sequencer.sv
// Randomized bench for adder_sequencer: two instances (read latency 1 and 3)
// share stimulus and are checked every cycle against a timeline model.
module tb_adder_sequencer;

   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          ok;
   logic [2:0]    ch;
   logic [AW-1:0] of_size;

   logic          re1, en1, we1, busy1, cfg1, fin1;
   logic [AW-1:0] rd1, wr1;
   logic [2:0]    cm1;
   logic          re3, en3, we3, busy3, cfg3, fin3;
   logic [AW-1:0] rd3, wr3;
   logic [2:0]    cm3;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cur_n;
   bit            cur_legal;
   logic [2:0]    cur_mask;
   bit            cfg_exp;

   always #5 clk = ~clk;

   adder_sequencer #(.MEM_RD_LATENCY(1)) dut1 (
      .ADDSEQ_Clk(clk), .ADDSEQ_Reset(rst), .ADDSEQ_Start_Routine(start),
      .ADDSEQ_Routine_Finished_Already_Ok(ok), .ADDSEQ_If_Channels(ch), .ADDSEQ_Of_Size(of_size),
      .ADDSEQ_Mems_Re(re1), .ADDSEQ_Mems_Rd_Addr(rd1), .ADDSEQ_Adder_En(en1),
      .ADDSEQ_Channel_Mask(cm1), .ADDSEQ_Out_Mem_We(we1), .ADDSEQ_Out_Mem_Wr_Addr(wr1),
      .ADDSEQ_Busy(busy1), .ADDSEQ_Config_Error(cfg1), .ADDSEQ_Routine_Finished_Already(fin1));

   adder_sequencer #(.MEM_RD_LATENCY(3)) dut3 (
      .ADDSEQ_Clk(clk), .ADDSEQ_Reset(rst), .ADDSEQ_Start_Routine(start),
      .ADDSEQ_Routine_Finished_Already_Ok(ok), .ADDSEQ_If_Channels(ch), .ADDSEQ_Of_Size(of_size),
      .ADDSEQ_Mems_Re(re3), .ADDSEQ_Mems_Rd_Addr(rd3), .ADDSEQ_Adder_En(en3),
      .ADDSEQ_Channel_Mask(cm3), .ADDSEQ_Out_Mem_We(we3), .ADDSEQ_Out_Mem_Wr_Addr(wr3),
      .ADDSEQ_Busy(busy3), .ADDSEQ_Config_Error(cfg3), .ADDSEQ_Routine_Finished_Already(fin3));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected outputs at cycle c after the start edge, derived from the routine timeline.
   task automatic check_dut(input string who, input int lat, input int c, input bit idle,
                            input logic re, input logic [AW-1:0] rd, input logic en,
                            input logic we, input logic [AW-1:0] wr, input logic busy,
                            input logic fin, input logic [2:0] cm, input logic cfg);
      bit         e_re, e_en, e_we, e_busy, e_fin;
      logic [2:0] e_cm;
      e_re = 1'b0; e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_fin = 1'b0; e_cm = 3'b000;
      if (!idle) begin
         if (cur_legal) begin
            e_re   = (c >= 1) && (c <= cur_n);
            e_en   = (c >= 1 + lat) && (c <= cur_n + lat);
            e_we   = (c >= 2 + lat) && (c <= cur_n + lat + 1);
            e_busy = (c >= 1) && (c <= cur_n + lat + 1);
            e_fin  = (c >= cur_n + lat + 2);
            e_cm   = cur_mask;
         end else begin
            e_fin = (c >= 1);
         end
      end
      check_eq({who, ".re"}, 32'(re), 32'(e_re));
      if (e_re) check_eq({who, ".rd_addr"}, 32'(rd), 32'(c - 1));
      check_eq({who, ".adder_en"}, 32'(en), 32'(e_en));
      check_eq({who, ".we"}, 32'(we), 32'(e_we));
      if (e_we) check_eq({who, ".wr_addr"}, 32'(wr), 32'(c - 2 - lat));
      check_eq({who, ".busy"}, 32'(busy), 32'(e_busy));
      check_eq({who, ".finished"}, 32'(fin), 32'(e_fin));
      check_eq({who, ".mask"}, 32'(cm), 32'(e_cm));
      check_eq({who, ".cfg_err"}, 32'(cfg), 32'(cfg_exp));
   endtask

   task automatic check_both(input int c, input bit idle);
      check_dut("lat1", 1, c, idle, re1, rd1, en1, we1, wr1, busy1, fin1, cm1, cfg1);
      check_dut("lat3", 3, c, idle, re3, rd3, en3, we3, wr3, busy3, fin3, cm3, cfg3);
   endtask

   // One routine: start, per-cycle checks, optional mid-run reset, then Ok handshake.
   task automatic run_routine(input int chn, input int ofs, input bit noise, input int abort_at);
      int last_c;
      @(negedge clk);
      ch        = chn[2:0];
      of_size   = AW'(ofs);
      start     = 1'b1;
      cur_legal = (chn >= 1) && (chn <= 3);
      cur_n     = ofs + 1;
      cur_mask  = cur_legal ? 3'((1 << chn) - 1) : 3'b000;
      cfg_exp   = !cur_legal;
      last_c    = (cur_legal ? cur_n + 3 + 2 : 1) + 2;
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clk);
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            ch      = 3'($urandom);
            of_size = AW'($urandom);
         end
         check_both(c, 1'b0);
         if (c == abort_at) begin
            start   = 1'b0;
            rst     = 1'b1;
            #1;
            cfg_exp = 1'b0;
            check_both(0, 1'b1);
            @(negedge clk);
            rst = 1'b0;
            check_both(0, 1'b1);
            return;
         end
      end
      ok    = 1'b1;
      start = noise;
      @(negedge clk);
      ok    = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_both(0, 1'b1);
         @(negedge clk);
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      ok      = 1'b0;
      ch      = 3'd0;
      of_size = '0;
      cfg_exp = 1'b0;
      cur_legal = 1'b0;
      cur_n   = 0;
      cur_mask = 3'b000;
      repeat (2) @(negedge clk);
      check_both(0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check_both(0, 1'b1);

      run_routine(3, 7, 1'b0, 0);
      run_routine(1, 0, 1'b0, 0);
      run_routine(0, 5, 1'b0, 0);
      run_routine(4, 5, 1'b0, 0);
      run_routine(2, 3, 1'b0, 0);
      run_routine(3, 10, 1'b0, 6);
      run_routine(2, 4, 1'b0, 0);
      run_routine(2, 6, 1'b1, 0);
      run_routine(3, 4, 1'b0, 0);
      repeat (14) begin
         run_routine(int'($urandom_range(0, 7)), int'($urandom_range(0, 20)),
                     1'($urandom_range(0, 1)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
